nes_pad_reader: RTL and testbench



---
 rtl/nes_pad_reader_if.sv | 17 +
 rtl/nes_pad_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_nes_pad_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nes_pad_reader_if.sv
// nes_pad_reader_if
//   Serial link between the pad reader and one NES-style controller.
//   Signals:
//     pad_latch - latch strobe, reader -> pad
//     pad_pulse - shift clock, reader -> pad
//     pad_data  - serial button data, pad -> reader, active-low, async to clk
//   Modports:
//     master - the reader (drives latch/pulse, receives data)
//     slave  - the pad side (receives latch/pulse, drives data)
interface nes_pad_reader_if;
  logic pad_latch;
  logic pad_pulse;
  logic pad_data;

  modport master (output pad_latch, output pad_pulse, input pad_data);
  modport slave  (input pad_latch, input pad_pulse, output pad_data);
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader
//   Reads one NES-style controller per frame_rate tick. It latches the pad,
//   shifts out eight bits (A, B, Select, Start, Up, Down, Left, Right) and
//   updates all eight button outputs together when the read completes.
//
//   Optional feature macro: PAD_DEBOUNCE_EN
//     When defined, a button output changes only when two consecutive
//     complete reads agree on that bit.
//
//   Parameters:
//     HALF_CYCLES - clk cycles per half-period of the pad pulse line (4..1023)
//   Ports:
//     clk         - system clock
//     reset       - asynchronous reset, active low
//     frame_rate  - one-cycle poll request, ignored while busy
//     pad         - pad link (nes_pad_reader_if.master)
//     button_*    - registered active-high pressed levels
//     pad_valid   - one-cycle pulse when the button outputs were just updated
//     busy        - high while a read is in progress
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | waiting for frame_rate, pad lines low
//   LATCH    | pad_latch high for two half-periods
//   SETTLE   | lines low one half-period, sample bit 0 on the last cycle
//   PULSE_HI | pad_pulse high one half-period
//   PULSE_LO | pad_pulse low one half-period, sample next bit on the last cycle
//   DONE     | button outputs show the new read, pad_valid high
module nes_pad_reader #(
  parameter int HALF_CYCLES = 150
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_rate,
  nes_pad_reader_if.master       pad,
  output logic                   button_a,
  output logic                   button_b,
  output logic                   button_select,
  output logic                   button_start,
  output logic                   button_up,
  output logic                   button_down,
  output logic                   button_left,
  output logic                   button_right,
  output logic                   pad_valid,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SETTLE   = 3'd2,
    PULSE_HI = 3'd3,
    PULSE_LO = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [9:0] HC_LAST = 10'(HALF_CYCLES - 1);

  state_t      state, next_state;
  logic [1:0]  sync_ff;
  logic        data_sync;
  logic [9:0]  hcnt;
  logic        tc;
  logic        latch_phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  sample_word;
  logic [7:0]  btn_q;
  logic        cnt_load;
  logic        sample;
  logic        done_load;
  logic        pad_latch_q;
  logic        pad_pulse_q;
  logic        pad_valid_q;
  logic        busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_ff <= 2'b00;
    else        sync_ff <= {sync_ff[0], pad.pad_data};
  end
  assign data_sync = sync_ff[1];

  // Half-period timer runs down to zero; every phase ends on terminal count.
  assign tc = (hcnt == 10'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    sample     = 1'b0;
    done_load  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_rate) begin
          next_state = LATCH;
          cnt_load   = 1'b1;
        end
      end
      LATCH: begin
        if (tc) begin
          cnt_load = 1'b1;
          if (latch_phase) next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (tc) begin
          sample     = 1'b1;
          cnt_load   = 1'b1;
          next_state = PULSE_HI;
        end
      end
      PULSE_HI: begin
        if (tc) begin
          cnt_load   = 1'b1;
          next_state = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (tc) begin
          sample   = 1'b1;
          cnt_load = 1'b1;
          if (bit_cnt == 3'd7) begin
            done_load  = 1'b1;
            next_state = DONE;
          end else begin
            next_state = PULSE_HI;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        hcnt <= 10'd0;
    else if (cnt_load) hcnt <= HC_LAST;
    else if (!tc)      hcnt <= hcnt - 10'd1;
  end

  // LATCH spans two half-periods; this flag marks the second one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    latch_phase <= 1'b0;
    else if (state != LATCH)       latch_phase <= 1'b0;
    else if (tc)                   latch_phase <= 1'b1;
  end

  // Bit counter is 0 at SETTLE and wraps back to 0 after the eighth sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                bit_cnt <= 3'd0;
    else if (state == IDLE)    bit_cnt <= 3'd0;
    else if (sample)           bit_cnt <= bit_cnt + 3'd1;
  end

  // Shift register contents with the bit being sampled this cycle merged in,
  // so the final sample reaches the outputs on the same edge.
  always_comb begin
    sample_word          = shreg;
    sample_word[bit_cnt] = ~data_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      shreg <= 8'd0;
    else if (sample) shreg <= sample_word;
  end

`ifdef PAD_DEBOUNCE_EN
  logic [7:0] prev_q;
  logic [7:0] agree;

  assign agree = ~(sample_word ^ prev_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 8'd0;
      btn_q  <= 8'd0;
    end else if (done_load) begin
      prev_q <= sample_word;
      btn_q  <= (sample_word & agree) | (btn_q & ~agree);
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         btn_q <= 8'd0;
    else if (done_load) btn_q <= sample_word;
  end
`endif

  // Pin and status outputs are registered from next_state so the pad lines
  // never see decode glitches and line up exactly with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad_latch_q <= 1'b0;
      pad_pulse_q <= 1'b0;
      pad_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pad_latch_q <= (next_state == LATCH);
      pad_pulse_q <= (next_state == PULSE_HI);
      pad_valid_q <= (next_state == DONE);
      busy_q      <= (next_state != IDLE);
    end
  end

  assign pad.pad_latch  = pad_latch_q;
  assign pad.pad_pulse  = pad_pulse_q;
  assign pad_valid      = pad_valid_q;
  assign busy           = busy_q;

  assign button_a       = btn_q[0];
  assign button_b       = btn_q[1];
  assign button_select  = btn_q[2];
  assign button_start   = btn_q[3];
  assign button_up      = btn_q[4];
  assign button_down    = btn_q[5];
  assign button_left    = btn_q[6];
  assign button_right   = btn_q[7];

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;
  localparam int H = 4;

  logic clk = 1'b0;
  logic reset;
  logic frame_rate;
  logic button_a, button_b, button_select, button_start;
  logic button_up, button_down, button_left, button_right;
  logic pad_valid, busy;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [7:0] pad_pressed;
  int         pad_idx;
  logic [7:0] exp_btn;
  logic [7:0] prev_read;

  nes_pad_reader_if pad_if ();

  nes_pad_reader #(.HALF_CYCLES(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_rate    (frame_rate),
    .pad           (pad_if),
    .button_a      (button_a),
    .button_b      (button_b),
    .button_select (button_select),
    .button_start  (button_start),
    .button_up     (button_up),
    .button_down   (button_down),
    .button_left   (button_left),
    .button_right  (button_right),
    .pad_valid     (pad_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Pad model: 4021-style shift register, bit index advances per pulse edge.
  initial pad_idx = 0;
  always @(posedge pad_if.pad_latch) pad_idx = 0;
  always @(posedge pad_if.pad_pulse) pad_idx = pad_idx + 1;
  assign pad_if.pad_data = (pad_idx < 8) ? ~pad_pressed[pad_idx[2:0]] : 1'b0;

  function automatic logic [7:0] btns();
    return {button_right, button_left, button_down, button_up,
            button_start, button_select, button_b, button_a};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One full read starting in the current cycle (cycle 0). poll_at > 0
  // drives an extra frame_rate while busy.
  task automatic do_read(input logic [7:0] pressed, input int poll_at);
    logic [7:0] old_btn;
    logic [7:0] new_btn;
    logic       l_exp, p_exp, v_exp, b_exp;
    old_btn = exp_btn;
`ifdef PAD_DEBOUNCE_EN
    new_btn = (pressed & ~(pressed ^ prev_read)) | (old_btn & (pressed ^ prev_read));
`else
    new_btn = pressed;
`endif
    prev_read   = pressed;
    pad_pressed = pressed;
    chk("idle_before_trigger", {7'd0, busy}, 8'd0);
    frame_rate = 1'b1;
    for (int c = 1; c <= 17*H + 2; c++) begin
      @(negedge clk);
      if (c == 1) frame_rate = 1'b0;
      if (poll_at > 0 && c == poll_at) frame_rate = 1'b1;
      if (poll_at > 0 && c == poll_at + 1) frame_rate = 1'b0;
      l_exp = (c >= 1 && c <= 2*H);
      p_exp = (c > 3*H) && (c <= 16*H) && ((((c - 3*H - 1) / H) % 2) == 0);
      v_exp = (c == 17*H + 1);
      b_exp = (c >= 1 && c <= 17*H + 1);
      chk("pad_latch", {7'd0, pad_if.pad_latch}, {7'd0, l_exp});
      chk("pad_pulse", {7'd0, pad_if.pad_pulse}, {7'd0, p_exp});
      chk("pad_valid", {7'd0, pad_valid}, {7'd0, v_exp});
      chk("busy", {7'd0, busy}, {7'd0, b_exp});
      chk("buttons", btns(), (c >= 17*H + 1) ? new_btn : old_btn);
    end
    exp_btn = new_btn;
  endtask

  initial begin
    reset       = 1'b0;
    frame_rate  = 1'b0;
    pad_pressed = 8'h00;
    exp_btn     = 8'h00;
    prev_read   = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_buttons", btns(), 8'h00);
    chk("reset_status", {4'd0, pad_if.pad_latch, pad_if.pad_pulse, pad_valid, busy}, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic read: Up and Right pressed.
    do_read(8'h90, 0);
`ifndef PAD_DEBOUNCE_EN
    chk("basic_up_right", btns(), 8'b1001_0000);
`endif
    // All pressed, then none pressed.
    do_read(8'hFF, 0);
    do_read(8'hFF, 0);
    chk("all_pressed", btns(), 8'hFF);
    do_read(8'h00, 0);
    do_read(8'h00, 0);
    chk("none_pressed", btns(), 8'h00);

    // Poll during busy is dropped; next read starts at cycle 70.
    do_read(8'h05, 30);
    do_read(8'h10, 0);
    do_read(8'h10, 0);
    chk("up_latched", btns(), 8'h10);

    // Reset at cycle 40 of a read.
    pad_pressed = 8'h22;
    frame_rate  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) frame_rate = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("midreset_buttons", btns(), 8'h00);
    chk("midreset_status", {4'd0, pad_if.pad_latch, pad_if.pad_pulse, pad_valid, busy}, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", {4'd0, pad_if.pad_latch, pad_if.pad_pulse, pad_valid, busy}, 8'h00);
    end
    exp_btn   = 8'h00;
    prev_read = 8'h00;
    do_read(8'h41, 0);
    do_read(8'h41, 0);
    chk("fresh_read", btns(), 8'h41);

    // Walking single press across A..Right.
    for (int i = 0; i < 8; i++) begin
      do_read(8'h01 << i, 0);
`ifndef PAD_DEBOUNCE_EN
      chk("bit_order", btns(), 8'h01 << i);
`endif
    end

    // Left pressed for one read only, then for two consecutive reads.
    do_read(8'h00, 0);
    do_read(8'h00, 0);
    do_read(8'h40, 0);
`ifdef PAD_DEBOUNCE_EN
    chk("left_single", {7'd0, button_left}, 8'd0);
`else
    chk("left_single", {7'd0, button_left}, 8'd1);
`endif
    do_read(8'h00, 0);
    chk("left_released", {7'd0, button_left}, 8'd0);
    do_read(8'h40, 0);
    do_read(8'h40, 0);
    chk("left_double", {7'd0, button_left}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
